alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single `alu` instance between two requesters, for example a debug/FPGA front end and a multicycle datapath. Each requester presents an opcode and two operands under a req/ack handshake. The block latches the winner's operands, runs the ALU for one cycle, and returns a registered result and flags with a one-cycle ack. It sits between the requesters and the `alu` it instantiates.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/alu_if.sv | 19 +
 rtl/alu.sv | 45 ++++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, ALU opcode encoding, and the
// state type for the ALU arbiter/sequencer.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_if.sv
// Connection bundle between an ALU user and the combinational alu.
//   master : drives aluop/porta/portb, receives portout and flags
//   slave  : the alu side
interface alu_if;
    import cpu_types_pkg::*;

    aluop_t aluop;
    word_t  porta;
    word_t  portb;
    word_t  portout;
    logic   negative;
    logic   overflow;
    logic   zero;

    modport master (output aluop, porta, portb,
                    input  portout, negative, overflow, zero);
    modport slave  (input  aluop, porta, portb,
                    output portout, negative, overflow, zero);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//   aluif.aluop/porta/portb : opcode and operands
//   aluif.portout           : result
//   aluif.negative          : result bit 31
//   aluif.overflow          : signed overflow (ADD/SUB only, else 0)
//   aluif.zero              : result is all zeros
module alu (
    alu_if.slave aluif
);
    import cpu_types_pkg::*;

    word_t out;
    logic  ovf;

    always_comb begin
        out = '0;
        ovf = 1'b0;
        case (aluif.aluop)
            ALU_SLL:  out = aluif.porta << aluif.portb[4:0];
            ALU_SRL:  out = aluif.porta >> aluif.portb[4:0];
            ALU_ADD: begin
                out = aluif.porta + aluif.portb;
                // same-sign operands producing a different-sign sum
                ovf = (aluif.porta[31] == aluif.portb[31]) && (out[31] != aluif.porta[31]);
            end
            ALU_SUB: begin
                out = aluif.porta - aluif.portb;
                // opposite-sign operands where the sign of A is not kept
                ovf = (aluif.porta[31] != aluif.portb[31]) && (out[31] != aluif.porta[31]);
            end
            ALU_AND:  out = aluif.porta & aluif.portb;
            ALU_OR:   out = aluif.porta | aluif.portb;
            ALU_XOR:  out = aluif.porta ^ aluif.portb;
            ALU_NOR:  out = ~(aluif.porta | aluif.portb);
            ALU_SLT:  out = {31'b0, $signed(aluif.porta) < $signed(aluif.portb)};
            ALU_SLTU: out = {31'b0, aluif.porta < aluif.portb};
            default:  out = '0;
        endcase
    end

    assign aluif.portout  = out;
    assign aluif.overflow = ovf;
    assign aluif.negative = out[31];
    assign aluif.zero     = (out == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu between two requesters.
// A request seen in IDLE is granted, its operands latched, the ALU runs
// for one cycle (EXEC), and a registered result/flags plus a one-cycle
// ack are presented in DONE.
//   CLK, RST              : clock, asynchronous active-high reset
//   req0/req1             : requests
//   aluop0/1, porta0/1,
//   portb0/1              : per-requester opcode and operands
//   ack0/ack1             : one-cycle completion pulse
//   result, negative,
//   overflow, zero        : registered result/flags of last completed op
//   busy                  : state is not IDLE
//   owner                 : requester granted most recently
module alu_arbiter
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   req0,
    input  logic   req1,
    input  aluop_t aluop0,
    input  aluop_t aluop1,
    input  word_t  porta0,
    input  word_t  porta1,
    input  word_t  portb0,
    input  word_t  portb1,
    output logic   ack0,
    output logic   ack1,
    output word_t  result,
    output logic   negative,
    output logic   overflow,
    output logic   zero,
    output logic   busy,
    output logic   owner
);

    arb_state_t state;
    aluop_t     op_q;
    word_t      a_q;
    word_t      b_q;
    logic       prio;
    logic       win;

    alu_if aluif ();

    // ALU sees only the latched operands, so requester changes after the
    // grant edge cannot disturb the op in flight.
    assign aluif.aluop = op_q;
    assign aluif.porta = a_q;
    assign aluif.portb = b_q;

    alu u_alu (
        .aluif (aluif.slave)
    );

    // Lone requester wins outright; on contention prio picks.
    assign win = (req0 && req1) ? prio : req1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            op_q     <= ALU_SLL;
            a_q      <= '0;
            b_q      <= '0;
            prio     <= 1'b0;
            owner    <= 1'b0;
            busy     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            result   <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        op_q  <= win ? aluop1 : aluop0;
                        a_q   <= win ? porta1 : porta0;
                        b_q   <= win ? portb1 : portb0;
                        owner <= win;
                        prio  <= ~win;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result   <= aluif.portout;
                    negative <= aluif.negative;
                    overflow <= aluif.overflow;
                    zero     <= aluif.zero;
                    // ack registered here so it is high exactly in DONE
                    ack0     <= ~owner;
                    ack1     <= owner;
                    state    <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by randomized
// two-requester traffic, checked against a cycle-level behavioural model.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST = 1'b0;
    logic  req0 = 1'b0;
    logic  req1 = 1'b0;
    logic  ack0, ack1, negative, overflow, zero, busy, owner;
    word_t result;

    // Per-requester bundles: operand side is driven by the bench, the
    // result side holds the expected response for that requester's op.
    alu_if bus0 ();
    alu_if bus1 ();

    int   checks   = 0;
    int   failures = 0;
    int   cyc_n, grant_c, ack_c;
    logic last_win, exp_owner;
    word_t exp_res;
    logic exp_n, exp_v, exp_z;
    logic gr [2];

    always #5 CLK = ~CLK;

    alu_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .req0     (req0),
        .req1     (req1),
        .aluop0   (bus0.aluop),
        .aluop1   (bus1.aluop),
        .porta0   (bus0.porta),
        .porta1   (bus1.porta),
        .portb0   (bus0.portb),
        .portb1   (bus1.portb),
        .ack0     (ack0),
        .ack1     (ack1),
        .result   (result),
        .negative (negative),
        .overflow (overflow),
        .zero     (zero),
        .busy     (busy),
        .owner    (owner)
    );

    // Reference ALU from arithmetic definitions: {negative, overflow, zero, result}
    function automatic logic [34:0] model_alu(input aluop_t op, input word_t a, input word_t b);
        longint sa, sb, s;
        word_t  r;
        logic   v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = '0;
        v  = 1'b0;
        case (op)
            ALU_ADD:  begin s = sa + sb; r = word_t'(s); v = (s != longint'($signed(r))); end
            ALU_SUB:  begin s = sa - sb; r = word_t'(s); v = (s != longint'($signed(r))); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  r = a << (b % 32);
            ALU_SRL:  r = a >> (b % 32);
            default:  r = '0;
        endcase
        return {r[31], v, (r == 32'd0), r};
    endfunction

    function automatic aluop_t rand_op();
        case ($urandom_range(0, 9))
            0: return ALU_SLL;
            1: return ALU_SRL;
            2: return ALU_ADD;
            3: return ALU_SUB;
            4: return ALU_AND;
            5: return ALU_OR;
            6: return ALU_XOR;
            7: return ALU_NOR;
            8: return ALU_SLT;
            default: return ALU_SLTU;
        endcase
    endfunction

    function automatic word_t rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return word_t'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int i, input logic r, input aluop_t op, input word_t a, input word_t b);
        if (i == 0) begin
            req0 = r; bus0.aluop = op; bus0.porta = a; bus0.portb = b;
        end else begin
            req1 = r; bus1.aluop = op; bus1.porta = a; bus1.portb = b;
        end
    endtask

    task automatic model_reset();
        cyc_n     = 0;
        grant_c   = -10;
        ack_c     = -10;
        last_win  = 1'b1;  // so requester 0 wins the first contention
        exp_owner = 1'b0;
        exp_res   = '0;
        exp_n     = 1'b0;
        exp_v     = 1'b0;
        exp_z     = 1'b0;
        gr[0]     = 1'b0;
        gr[1]     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"},     ack0,     32'd0);
        check({tag, "_ack1"},     ack1,     32'd0);
        check({tag, "_result"},   result,   32'd0);
        check({tag, "_negative"}, negative, 32'd0);
        check({tag, "_overflow"}, overflow, 32'd0);
        check({tag, "_zero"},     zero,     32'd0);
        check({tag, "_busy"},     busy,     32'd0);
        check({tag, "_owner"},    owner,    32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        model_reset();
    endtask

    // Grant decision for the current cycle, made after inputs are set.
    // The arbiter is free from 3 cycles after its last grant onwards.
    task automatic commit();
        logic w;
        if (cyc_n >= grant_c + 3 && (req0 || req1)) begin
            w         = (req0 && req1) ? ~last_win : req1;
            grant_c   = cyc_n;
            ack_c     = cyc_n + 2;
            last_win  = w;
            exp_owner = w;
            gr[w]     = 1'b1;
            if (w)
                {bus1.negative, bus1.overflow, bus1.zero, bus1.portout} =
                    model_alu(bus1.aluop, bus1.porta, bus1.portb);
            else
                {bus0.negative, bus0.overflow, bus0.zero, bus0.portout} =
                    model_alu(bus0.aluop, bus0.porta, bus0.portb);
        end
    endtask

    // Advance one cycle and compare every output with the model.
    task automatic cyc();
        @(negedge CLK);
        cyc_n++;
        if (cyc_n == ack_c) begin
            exp_res = exp_owner ? bus1.portout  : bus0.portout;
            exp_n   = exp_owner ? bus1.negative : bus0.negative;
            exp_v   = exp_owner ? bus1.overflow : bus0.overflow;
            exp_z   = exp_owner ? bus1.zero     : bus0.zero;
        end
        check("ack0",     ack0,     32'((cyc_n == ack_c) && !exp_owner));
        check("ack1",     ack1,     32'((cyc_n == ack_c) && exp_owner));
        check("ack_excl", ack0 & ack1, 32'd0);
        check("busy",     busy,     32'((cyc_n > grant_c) && (cyc_n <= grant_c + 2)));
        check("owner",    owner,    32'(exp_owner));
        check("result",   result,   exp_res);
        check("negative", negative, 32'(exp_n));
        check("overflow", overflow, 32'(exp_v));
        check("zero",     zero,     32'(exp_z));
    endtask

    task automatic next();
        commit();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, ALU_ADD, '0, '0);
        drive(1, 1'b0, ALU_ADD, '0, '0);
        do_reset();

        // req0 ADD 5+7
        drive(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        next();
        check("add_busy_c1", busy, 32'd1);
        check("add_ack0_c1", ack0, 32'd0);
        next();
        check("add_ack0_c2", ack0, 32'd1);
        check("add_ack1_c2", ack1, 32'd0);
        check("add_busy_c2", busy, 32'd1);
        check("add_result",  result, 32'd12);
        check("add_zero",    zero, 32'd0);
        check("add_neg",     negative, 32'd0);
        req0 = 1'b0;
        next();
        check("add_busy_c3", busy, 32'd0);
        check("add_ack0_c3", ack0, 32'd0);

        // req1 SUB 3-3
        drive(1, 1'b1, ALU_SUB, 32'd3, 32'd3);
        next();
        next();
        check("sub_ack1",   ack1, 32'd1);
        check("sub_result", result, 32'd0);
        check("sub_zero",   zero, 32'd1);
        req1 = 1'b0;
        next();

        // req1 ADD signed overflow
        drive(1, 1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        next();
        next();
        check("ovf_ack1",   ack1, 32'd1);
        check("ovf_result", result, 32'h8000_0000);
        check("ovf_flag",   overflow, 32'd1);
        check("ovf_neg",    negative, 32'd1);
        req1 = 1'b0;
        next();
        check("hold_result", result, 32'h8000_0000);

        // operand change during EXEC is ignored
        drive(0, 1'b1, ALU_ADD, 32'd100, 32'd1);
        next();
        bus0.porta = 32'd999;
        next();
        check("latch_ack0",   ack0, 32'd1);
        check("latch_result", result, 32'd101);
        req0 = 1'b0;
        next();

        // reset during EXEC of a requester-0 op
        drive(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        next();
        check("mid_busy", busy, 32'd1);
        req0 = 1'b0;
        RST  = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        repeat (3) begin
            next();
            check("midrst_noack0", ack0, 32'd0);
        end
        // priority pointer was cleared: contention goes to requester 0
        drive(0, 1'b1, ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        drive(1, 1'b1, ALU_OR,  32'h0000_00F0, 32'h0000_000F);
        next();
        next();
        check("postrst_ack0",   ack0, 32'd1);
        check("postrst_result", result, 32'hFF00_FF00);
        req0 = 1'b0;
        next();
        next();
        next();
        check("postrst_ack1",   ack1, 32'd1);
        check("postrst_result1", result, 32'h0000_00FF);
        req1 = 1'b0;
        next();

        // continuous contention from reset: grants alternate 0,1,0,1
        drive(0, 1'b1, ALU_ADD, 32'd10, 32'd20);
        drive(1, 1'b1, ALU_SUB, 32'd50, 32'd8);
        do_reset();
        for (int k = 0; k < 12; k++) begin
            next();
            check("rr_ack0", ack0, 32'((cyc_n == 2) || (cyc_n == 8)));
            check("rr_ack1", ack1, 32'((cyc_n == 5) || (cyc_n == 11)));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        next();
        next();

        // randomized traffic
        drive(0, 1'b0, ALU_ADD, '0, '0);
        drive(1, 1'b0, ALU_ADD, '0, '0);
        do_reset();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc_n == ack_c && int'(exp_owner) == i) begin
                    if (i == 0) req0 = 1'b0; else req1 = 1'b0;
                    gr[i] = 1'b0;
                end else if (gr[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        if (i == 0) req0 = 1'b0; else req1 = 1'b0;
                    end
                    if ($urandom_range(0, 1) == 1)
                        drive(i, (i == 0) ? req0 : req1, rand_op(), rand_word(), rand_word());
                end else if (((i == 0) ? req0 : req1) == 1'b0 && $urandom_range(0, 2) == 0) begin
                    drive(i, 1'b1, rand_op(), rand_word(), rand_word());
                end
            end
            next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
